// File: rtl/ysyx_25030085_mem_resp.sv
// rtl/ysyx_25030085_mem_resp.sv - fixed-latency data-memory responder for the LSU
// Optional macro YSYX_25030085_MEM_RESP_RAND_DELAY_EN adds 0..7 LFSR-driven extra cycles per request.
module ysyx_25030085_mem_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         CNT_W  = 5;
  localparam int         WORDS  = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'd4 << DEPTH_LOG2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wen;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wmask;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [WORDS];

  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_do_access;
  logic [CNT_W-1:0]      w_cnt_load;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the unsigned compare.
  assign w_off       = r_addr - BASE_ADDR;
  assign w_in_range  = (w_off < SPAN);
  assign w_idx       = w_off[DEPTH_LOG2+1:2];
  assign w_do_access = (r_state == S_WAIT) && (r_cnt == '0);

`ifdef YSYX_25030085_MEM_RESP_RAND_DELAY_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_cnt_load = CNT_W'(LATENCY - 1) + {2'b00, r_lfsr[2:0]};
`else
  assign w_cnt_load = CNT_W'(LATENCY - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            r_cnt   <= w_cnt_load;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= (w_in_range && !r_wen) ? r_mem[w_idx] : 32'd0;
            r_err   <= !w_in_range;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset forces r_state to IDLE, so an abandoned write never reaches this port.
  always_ff @(posedge clk) begin
    if (w_do_access && r_wen && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
